// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan controller: FSM encodings and channel indices.
package mux_scan_ctrl_pkg;

  typedef logic [1:0] ch_idx_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam ch_idx_t CH_A = 2'd0;
  localparam ch_idx_t CH_B = 2'd1;
  localparam ch_idx_t CH_C = 2'd2;
  localparam ch_idx_t CH_D = 2'd3;

  function automatic logic is_busy(input logic [1:0] st);
    return (st == ST_SETTLE) || (st == ST_SAMPLE);
  endfunction

endpackage

// File: rtl/mux41.sv
// 4:1 mux that the scan controller sequences; {s1,s0} selects a..d.
module mux41 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic s1,
  input  logic s0,
  output logic o
);

  always_comb begin
    o = a;
    case ({s1, s0})
      2'b00:   o = a;
      2'b01:   o = b;
      2'b10:   o = c;
      default: o = d;
    endcase
  end

endmodule

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Settle timer: cleared by load, counts up while enabled, flags the last settle cycle.
module mux_scan_ctrl_settle_timer #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(SETTLE_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Exact compare: the FSM leaves SETTLE on this cycle, so the count never wraps.
  assign done = en && (cnt == TC);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Round-robin scan of a 4:1 mux: settle on each channel, sample o_in, publish a 4-bit word.
//   state  | meaning
//   IDLE   | selects parked at 00, waiting for start or cont
//   SETTLE | select = k, waiting SETTLE_CYC cycles
//   SAMPLE | one cycle; o_in captured into bit k at the closing edge
//   DONE   | one cycle; word updated, word_valid high
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       o_in,
  output logic       s1,
  output logic       s0,
  output logic [3:0] word,
  output logic       word_valid,
  output logic       busy
);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 15 || (2 ** CNT_W) <= SETTLE_CYC) begin : g_bad_param
    $error("mux_scan_ctrl: SETTLE_CYC must be 1..15 and fit in CNT_W bits");
  end

  logic [1:0] state;
  logic [1:0] state_nxt;
  ch_idx_t    k;
  ch_idx_t    k_nxt;
  logic [3:0] cap;
  logic       timer_done;

  mux_scan_ctrl_settle_timer #(
    .SETTLE_CYC(SETTLE_CYC),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(state != ST_SETTLE),
    .en  (state == ST_SETTLE),
    .done(timer_done)
  );

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      ST_IDLE: begin
        k_nxt = CH_A;
        if (start || cont) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (timer_done) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (k == CH_D) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_SETTLE;
          k_nxt     = k + 2'd1;
        end
      end
      default: begin
        k_nxt     = CH_A;
        state_nxt = (start || cont) ? ST_SETTLE : ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      k          <= CH_A;
      cap        <= 4'h0;
      word       <= 4'h0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      s1         <= 1'b0;
      s0         <= 1'b0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (state == ST_SAMPLE) begin
        cap[k] <= o_in;
        // Last channel goes straight into word so it is visible during DONE.
        if (k == CH_D) word <= {o_in, cap[2:0]};
      end
      word_valid <= (state_nxt == ST_DONE);
      busy       <= is_busy(state_nxt);
      {s1, s0}   <= is_busy(state_nxt) ? k_nxt : 2'b00;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: directed scan vectors, corner sequences, random run against a model.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b0, start0 = 1'b0, cont0 = 1'b0;
  logic [3:0] in0 = 4'h0;
  logic       s1_0, s0_0, o0, wv0, busy0;
  logic [3:0] word0;

  logic       rst1 = 1'b0, start1 = 1'b0, cont1 = 1'b0;
  logic [3:0] in1 = 4'h0;
  logic       s1_1, s0_1, o1, wv1, busy1;
  logic [3:0] word1;

  mux41 u_mux0 (.a(in0[0]), .b(in0[1]), .c(in0[2]), .d(in0[3]), .s1(s1_0), .s0(s0_0), .o(o0));
  mux_scan_ctrl #(.SETTLE_CYC(2), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst0), .start(start0), .cont(cont0), .o_in(o0),
    .s1(s1_0), .s0(s0_0), .word(word0), .word_valid(wv0), .busy(busy0)
  );

  mux41 u_mux1 (.a(in1[0]), .b(in1[1]), .c(in1[2]), .d(in1[3]), .s1(s1_1), .s0(s0_1), .o(o1));
  mux_scan_ctrl #(.SETTLE_CYC(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .cont(cont1), .o_in(o1),
    .s1(s1_1), .s0(s0_1), .word(word1), .word_valid(wv1), .busy(busy1)
  );

  // Reference model: position within a scan as a plain phase count.
  typedef struct packed {
    logic       scanning;
    logic [7:0] ph;
    logic [3:0] cap;
    logic [3:0] word;
    logic       wv;
  } mdl_t;

  function automatic mdl_t mdl_step(input mdl_t m, input int s, input logic r,
                                    input logic st, input logic ct, input logic [3:0] abcd);
    mdl_t n;
    int   per;
    int   ch;
    n   = m;
    per = s + 1;
    ch  = int'(m.ph) / per;
    if (r) begin
      n = '0;
    end else if (m.scanning) begin
      if (int'(m.ph) % per == s) n.cap[ch] = abcd[ch];
      n.ph = m.ph + 8'd1;
      n.wv = 1'b0;
      if (int'(n.ph) == 4 * per) begin
        n.scanning = 1'b0;
        n.wv       = 1'b1;
        n.word     = n.cap;
      end
    end else begin
      n.wv = 1'b0;
      if (st || ct) begin
        n.scanning = 1'b1;
        n.ph       = 8'd0;
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] mdl_out(input mdl_t m, input int s);
    logic [1:0] sel;
    sel = m.scanning ? 2'(int'(m.ph) / (s + 1)) : 2'b00;
    return {sel, m.word, m.wv, m.scanning};
  endfunction

  mdl_t m0 = '0, m1 = '0;
  always @(posedge clk) begin
    m0 <= mdl_step(m0, 2, rst0, start0, cont0, in0);
    m1 <= mdl_step(m1, 1, rst1, start1, cont1, in1);
  end

  wire [7:0] pack0 = {s1_0, s0_0, word0, wv0, busy0};
  wire [7:0] pack1 = {s1_1, s0_1, word1, wv1, busy1};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       start;
    logic [1:0] sel;
    logic       busy;
    logic       wv;
    logic [3:0] word;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int t;
    int cnt;

    // Single scan with a=1,b=0,c=1,d=0; starts at rows 3 and 7 land mid-scan.
    for (int i = 0; i < 15; i++) begin
      tbl[i].start = (i == 0) || (i == 3) || (i == 7);
      tbl[i].sel   = (i < 12) ? 2'(i / 3) : 2'b00;
      tbl[i].busy  = (i < 12);
      tbl[i].wv    = (i == 12);
      tbl[i].word  = (i >= 12) ? 4'b0101 : 4'b0000;
    end

    @(negedge clk);
    rst0 = 1'b1; rst1 = 1'b1;
    tick();
    rst0 = 1'b0; rst1 = 1'b0;
    check("reset_state0", 32'(pack0), 32'h0);
    check("reset_state1", 32'(pack1), 32'h0);

    in0 = 4'b0101;
    for (int i = 0; i < 15; i++) begin
      start0 = tbl[i].start;
      tick();
      check($sformatf("scan_row%0d", i), 32'(pack0),
            32'({tbl[i].sel, tbl[i].word, tbl[i].wv, tbl[i].busy}));
    end
    start0 = 1'b0;

    // Continuous mode, all inputs high.
    in0   = 4'hF;
    cont0 = 1'b1;
    t = 0;
    while (!wv0 && t < 40) begin tick(); t++; end
    check("cont_first_wv", 32'(wv0), 32'h1);
    check("cont_first_word", 32'(word0), 32'hF);
    t = 0;
    do begin tick(); t++; end while (!wv0 && t < 40);
    check("cont_period", 32'(t), 32'd13);
    for (int i = 0; i < 5; i++) tick();
    cont0 = 1'b0;
    t = 0;
    do begin tick(); t++; end while (!wv0 && t < 40);
    check("cont_drop_completes", 32'(t), 32'd8);
    check("cont_drop_word", 32'(word0), 32'hF);
    tick();
    check("cont_drop_idle", 32'(pack0), 32'({2'b00, 4'hF, 1'b0, 1'b0}));
    cnt = 0;
    for (int i = 0; i < 15; i++) begin tick(); cnt += int'(wv0) + int'(busy0); end
    check("cont_drop_stays_idle", 32'(cnt), 32'd0);

    // Reset in the middle of a scan.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("rst_mid_busy_before", 32'(busy0), 32'h1);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    check("rst_mid_state", 32'(pack0), 32'h0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); cnt += int'(wv0) + int'(busy0); end
    check("rst_mid_no_wv", 32'(cnt), 32'd0);

    // SETTLE_CYC=1: only d high when sampled; o_in toggles opposite during settle cycles.
    for (int j = 0; j < 10; j++) begin
      start1 = (j == 0);
      in1    = (j > 0 && j % 2 == 0) ? 4'b1000 : 4'b0111;
      tick();
      check($sformatf("s1_row%0d", j), 32'(pack1),
            32'({(j < 8) ? 2'(j / 2) : 2'b00, (j >= 8) ? 4'b1000 : 4'b0000,
                 1'(j == 8), 1'(j < 8)}));
    end
    start1 = 1'b0;

    // Randomized run against the model.
    rst0 = 1'b1; rst1 = 1'b1;
    tick();
    rst0 = 1'b0; rst1 = 1'b0;
    for (int i = 0; i < 800; i++) begin
      rst0   = ($urandom_range(0, 99) == 0);
      rst1   = ($urandom_range(0, 99) == 0);
      start0 = ($urandom_range(0, 9) < 3);
      start1 = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 19) == 0) cont0 = ~cont0;
      if ($urandom_range(0, 19) == 0) cont1 = ~cont1;
      in0 = 4'($urandom);
      in1 = 4'($urandom);
      tick();
      check($sformatf("rand0_c%0d", i), 32'(pack0), 32'(mdl_out(m0, 2)));
      check($sformatf("rand1_c%0d", i), 32'(pack1), 32'(mdl_out(m1, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
